// File: rtl/vga_shift_in.sv
// Serial-to-parallel pixel capture: MSB-first byte assembly, column tagging, 2-entry output FIFO.
// Optional build macro SHIFTIN_INVERT_EN inverts serIn for active-low video sources.
module vga_shift_in #(
  parameter int BYTES_PER_LINE = 64,
  parameter int ADDR_W         = 6
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              nLineStart,
  input  logic              sampleEn,
  input  logic              serIn,
  input  logic              outReady,
  output logic              outValid,
  output logic [7:0]        parOut,
  output logic [ADDR_W-1:0] colAddr,
  output logic              lineDone,
  output logic              overflow,
  input  logic              nClrOvf
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(BYTES_PER_LINE - 1);

  state_t            state;
  state_t            stateNext;
  logic [6:0]        shiftReg;
  logic [6:0]        shiftNext;
  logic [2:0]        bitCnt;
  logic [2:0]        bitCntNext;
  logic [ADDR_W-1:0] colCnt;
  logic [ADDR_W-1:0] colCntNext;
  logic              lineDoneNext;

  logic              bitIn;
  logic              push;
  logic [7:0]        pushData;
  logic              pop;

  logic [1:0]        count;
  logic [1:0]        countNext;
  logic [7:0]        tailData;
  logic [7:0]        tailDataNext;
  logic [ADDR_W-1:0] tailCol;
  logic [ADDR_W-1:0] tailColNext;
  logic [7:0]        headDataNext;
  logic [ADDR_W-1:0] headColNext;
  logic              outValidNext;
  logic              overflowNext;
  logic              ovfSet;

`ifdef SHIFTIN_INVERT_EN
  assign bitIn = ~serIn;
`else
  assign bitIn = serIn;
`endif

  assign pushData = {shiftReg, bitIn};

  // Line FSM: next state, shift/bit/column counters and byte-complete push.
  always_comb begin
    stateNext    = state;
    shiftNext    = shiftReg;
    bitCntNext   = bitCnt;
    colCntNext   = colCnt;
    push         = 1'b0;
    lineDoneNext = 1'b0;
    case (state)
      IDLE: begin
        if (!nLineStart) begin
          stateNext  = ACTIVE;
          shiftNext  = 7'd0;
          bitCntNext = 3'd0;
          colCntNext = {ADDR_W{1'b0}};
        end else begin
          stateNext = IDLE;
        end
      end
      ACTIVE: begin
        if (sampleEn) begin
          shiftNext  = pushData[6:0];
          bitCntNext = bitCnt + 3'd1;
          if (bitCnt == 3'd7) begin
            push = 1'b1;
            if (colCnt == LAST_COL) begin
              lineDoneNext = 1'b1;
              stateNext    = IDLE;
              colCntNext   = {ADDR_W{1'b0}};
            end else begin
              colCntNext = colCnt + ADDR_W'(1);
            end
          end else begin
            colCntNext = colCnt;
          end
        end else begin
          shiftNext = shiftReg;
        end
        // A restart discards the partial byte but lets a completing byte push first.
        if (!nLineStart) begin
          stateNext  = ACTIVE;
          shiftNext  = 7'd0;
          bitCntNext = 3'd0;
          colCntNext = {ADDR_W{1'b0}};
        end else begin
          bitCntNext = bitCntNext;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Two-entry FIFO held as head (drives outputs directly) and tail registers.
  always_comb begin
    pop          = (count != 2'd0) && outReady;
    countNext    = count;
    headDataNext = parOut;
    headColNext  = colAddr;
    tailDataNext = tailData;
    tailColNext  = tailCol;
    ovfSet       = 1'b0;
    case ({push, pop})
      2'b10: begin
        case (count)
          2'd0: begin
            headDataNext = pushData;
            headColNext  = colCnt;
            countNext    = 2'd1;
          end
          2'd1: begin
            tailDataNext = pushData;
            tailColNext  = colCnt;
            countNext    = 2'd2;
          end
          default: begin
            ovfSet = 1'b1;
          end
        endcase
      end
      2'b01: begin
        if (count == 2'd2) begin
          headDataNext = tailData;
          headColNext  = tailCol;
        end else begin
          headDataNext = parOut;
        end
        countNext = count - 2'd1;
      end
      2'b11: begin
        if (count == 2'd2) begin
          headDataNext = tailData;
          headColNext  = tailCol;
          tailDataNext = pushData;
          tailColNext  = colCnt;
        end else begin
          headDataNext = pushData;
          headColNext  = colCnt;
        end
      end
      default: begin
        countNext = count;
      end
    endcase
    if (ovfSet) begin
      overflowNext = 1'b1;
    end else if (!nClrOvf) begin
      overflowNext = 1'b0;
    end else begin
      overflowNext = overflow;
    end
    outValidNext = (countNext != 2'd0);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Datapath, FIFO and registered output flops.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      shiftReg <= 7'd0;
      bitCnt   <= 3'd0;
      colCnt   <= {ADDR_W{1'b0}};
      count    <= 2'd0;
      tailData <= 8'd0;
      tailCol  <= {ADDR_W{1'b0}};
      parOut   <= 8'd0;
      colAddr  <= {ADDR_W{1'b0}};
      outValid <= 1'b0;
      lineDone <= 1'b0;
      overflow <= 1'b0;
    end else begin
      shiftReg <= shiftNext;
      bitCnt   <= bitCntNext;
      colCnt   <= colCntNext;
      count    <= countNext;
      tailData <= tailDataNext;
      tailCol  <= tailColNext;
      parOut   <= headDataNext;
      colAddr  <= headColNext;
      outValid <= outValidNext;
      lineDone <= lineDoneNext;
      overflow <= overflowNext;
    end
  end

endmodule

// File: tb/tb_vga_shift_in.sv
// Directed scoreboard bench for vga_shift_in; expected bytes are queued as they are driven.
module tb_vga_shift_in;
  localparam int BPL = 64;
  localparam int AW  = 6;
`ifdef SHIFTIN_INVERT_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          nReset;
  logic          nLineStart;
  logic          sampleEn;
  logic          serIn;
  logic          outReady;
  logic          outValid;
  logic [7:0]    parOut;
  logic [AW-1:0] colAddr;
  logic          lineDone;
  logic          overflow;
  logic          nClrOvf;

  logic [AW+7:0] sbQ[$];
  int            tests = 0;
  int            failed = 0;
  int            validCycles = 0;
  int            ldCount = 0;
  logic [AW-1:0] lastLdCol = '0;

  vga_shift_in #(.BYTES_PER_LINE(BPL), .ADDR_W(AW)) dut (
    .clk(clk), .nReset(nReset), .nLineStart(nLineStart), .sampleEn(sampleEn),
    .serIn(serIn), .outReady(outReady), .outValid(outValid), .parOut(parOut),
    .colAddr(colAddr), .lineDone(lineDone), .overflow(overflow), .nClrOvf(nClrOvf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, score any handshake taking place at this edge, then sample.
  task automatic step(input logic ls, input logic se, input logic si);
    logic [AW+7:0] e;
    nLineStart = ls;
    sampleEn   = se;
    serIn      = si;
    if (outValid && outReady) begin
      if (sbQ.size() == 0) begin
        chk("sb_unexpected_byte", 32'(sbQ.size()), 32'd1);
      end else begin
        e = sbQ.pop_front();
        chk("sb_col", 32'(colAddr), 32'(e[AW+7:8]));
        chk("sb_data", 32'(parOut), 32'(e[7:0]));
      end
    end
    @(posedge clk);
    #1;
    if (outValid) validCycles++;
    if (lineDone) begin
      ldCount++;
      lastLdCol = colAddr;
    end
  endtask

  // Shift one byte as it appears on the wire; queue the expected captured value if it should survive.
  task automatic sendByte(input logic [7:0] wire8, input int col, input bit keep);
    logic [7:0] expByte;
    expByte = INV ? ~wire8 : wire8;
    if (keep) sbQ.push_back({AW'(col), expByte});
    for (int i = 7; i >= 0; i--) step(1'b1, 1'b1, wire8[i]);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 10 && sbQ.size() != 0; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk(tag, 32'(sbQ.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] w;
    nReset = 1'b0; nLineStart = 1'b1; sampleEn = 1'b0; serIn = 1'b0;
    outReady = 1'b1; nClrOvf = 1'b1;
    #12;
    chk("rst_valid", 32'(outValid), 32'd0);
    chk("rst_par", 32'(parOut), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    @(posedge clk); #1;
    nReset = 1'b1;

    // Single byte: wire 1,0,1,0,0,1,0,1
    step(1'b0, 1'b0, 1'b0);
    validCycles = 0;
    w = INV ? 8'h5A : 8'hA5;
    sendByte(w, 0, 1'b1);
    chk("single_par", 32'(parOut), 32'hA5);
    chk("single_col", 32'(colAddr), 32'd0);
    drain("single_drain");
    chk("single_valid_cycles", 32'(validCycles), 32'd1);

    // Reset mid-line after 3 bits
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
    nReset = 1'b0;
    #2;
    chk("midrst_valid", 32'(outValid), 32'd0);
    chk("midrst_par", 32'(parOut), 32'd0);
    chk("midrst_col", 32'(colAddr), 32'd0);
    chk("midrst_ld", 32'(lineDone), 32'd0);
    chk("midrst_ovf", 32'(overflow), 32'd0);
    @(posedge clk); #1;
    nReset = 1'b1;
    sampleEn = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    chk("midrst_idle_ignores", 32'(outValid), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    sendByte(8'h3C, 0, 1'b1);
    chk("midrst_col0", 32'(colAddr), 32'd0);
    drain("midrst_drain");

    // Full line
    step(1'b0, 1'b0, 1'b0);
    ldCount = 0;
    for (int c = 0; c < BPL; c++) sendByte(8'($urandom_range(0, 255)), c, 1'b1);
    chk("line_ld_col", 32'(lastLdCol), 32'(BPL - 1));
    drain("line_drain");
    validCycles = 0;
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b1);
    chk("line_extra_nopush", 32'(validCycles), 32'd0);
    chk("line_ld_once", 32'(ldCount), 32'd1);

    // Backpressure and overflow
    step(1'b0, 1'b0, 1'b0);
    outReady = 1'b0;
    sendByte(8'h11, 0, 1'b1);
    sendByte(8'h22, 1, 1'b1);
    chk("bp_no_ovf_yet", 32'(overflow), 32'd0);
    sendByte(8'h33, 2, 1'b0);
    chk("bp_ovf_set", 32'(overflow), 32'd1);
    chk("bp_head_col", 32'(colAddr), 32'd0);
    outReady = 1'b1;
    sendByte(8'h44, 3, 1'b1);
    drain("bp_drain");
    chk("bp_ovf_sticky", 32'(overflow), 32'd1);
    nClrOvf = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    nClrOvf = 1'b1;
    chk("bp_ovf_clr", 32'(overflow), 32'd0);

    // Restart mid-byte with bytes still queued
    step(1'b0, 1'b0, 1'b0);
    outReady = 1'b0;
    sendByte(8'h81, 0, 1'b1);
    sendByte(8'h42, 1, 1'b1);
    sendByte(8'h24, 2, 1'b0);
    sendByte(8'h18, 3, 1'b0);
    sendByte(8'hFF, 4, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk("rs_held_col", 32'(colAddr), 32'd0);
    outReady = 1'b1;
    sendByte(8'h96, 0, 1'b1);
    drain("rs_drain");

    // Wire pattern 5A (captured as A5 when inverting)
    step(1'b0, 1'b0, 1'b0);
    sendByte(8'h5A, 0, 1'b1);
    chk("inv_par", 32'(parOut), INV ? 32'hA5 : 32'h5A);
    drain("inv_drain");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
